// File: rtl/reg_file.sv
// 32 x 64-bit register file for the ID stage: two combinational read ports,
// one synchronous WB write port, optional same-cycle write-to-read bypass.
module reg_file #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] R1addr,
  input  logic [ADDR_W-1:0] R2addr,
  input  logic              WB_WRegEn,
  input  logic [ADDR_W-1:0] WB_WReg1,
  input  logic [DATA_W-1:0] WB_WData,
  output logic [DATA_W-1:0] ID_R1out,
  output logic [DATA_W-1:0] ID_R2out
);

  localparam bit BYPASS_EN = (BYPASS != 0);

  // Flop array (not RAM) so the asynchronous clear and combinational reads hold.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (WB_WRegEn) begin
      mem[WB_WReg1] <= WB_WData;
    end
  end

  logic hit1;
  logic hit2;

  assign hit1 = BYPASS_EN && WB_WRegEn && (WB_WReg1 == R1addr);
  assign hit2 = BYPASS_EN && WB_WRegEn && (WB_WReg1 == R2addr);

  // Outputs are forced to zero while reset is low, which also blocks the bypass.
  always_comb begin
    ID_R1out = '0;
    ID_R2out = '0;
    if (reset) begin
      ID_R1out = hit1 ? WB_WData : mem[R1addr];
      ID_R2out = hit2 ? WB_WData : mem[R2addr];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: one BYPASS=1 and one BYPASS=0 instance share
// all inputs; a negedge monitor pops expected read data from a queue.
module tb_reg_file;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] R1addr;
  logic [ADDR_W-1:0] R2addr;
  logic              WB_WRegEn;
  logic [ADDR_W-1:0] WB_WReg1;
  logic [DATA_W-1:0] WB_WData;
  logic [DATA_W-1:0] r1_byp, r2_byp, r1_nb, r2_nb;

  logic [DATA_W-1:0] exp_q[$];
  string             tag_q[$];
  logic              sample_req;
  int                checks;
  int                errors;

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(32), .BYPASS(1)) dut_byp (
    .clk(clk), .reset(reset), .R1addr(R1addr), .R2addr(R2addr),
    .WB_WRegEn(WB_WRegEn), .WB_WReg1(WB_WReg1), .WB_WData(WB_WData),
    .ID_R1out(r1_byp), .ID_R2out(r2_byp)
  );

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(32), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .R1addr(R1addr), .R2addr(R2addr),
    .WB_WRegEn(WB_WRegEn), .WB_WReg1(WB_WReg1), .WB_WData(WB_WData),
    .ID_R1out(r1_nb), .ID_R2out(r2_nb)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2,
                     input logic [DATA_W-1:0] n1, input logic [DATA_W-1:0] n2);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    exp_q.push_back(n1);
    exp_q.push_back(n2);
    tag_q.push_back(tag);
    sample_req = 1'b1;
    @(negedge clk);
    #1;
    sample_req = 1'b0;
  endtask

  task automatic chk2(input string tag, input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2);
    chk(tag, e1, e2, e1, e2);
  endtask

  task automatic set_wr(input logic en, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    WB_WRegEn = en;
    WB_WReg1  = a;
    WB_WData  = d;
  endtask

  // scoreboard
  task automatic cmp(input string tag, input string port, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h want %h", tag, port, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sample_req) begin
      if (exp_q.size() < 4 || tag_q.size() < 1) begin
        checks++;
        errors++;
        $display("FAIL monitor: expected queue underflow");
      end else begin
        string            t;
        logic [DATA_W-1:0] e1, e2, n1, n2;
        t  = tag_q.pop_front();
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        n1 = exp_q.pop_front();
        n2 = exp_q.pop_front();
        cmp(t, "byp_r1", r1_byp, e1);
        cmp(t, "byp_r2", r2_byp, e2);
        cmp(t, "nb_r1", r1_nb, n1);
        cmp(t, "nb_r2", r2_nb, n2);
      end
    end
  end

  // stimulus
  initial begin
    checks     = 0;
    errors     = 0;
    sample_req = 1'b0;
    R1addr     = '0;
    R2addr     = '0;
    set_wr(1'b0, '0, '0);
    reset      = 1'b1;
    #1;
    reset      = 1'b0;

    // 1: reset held low with a pending write to reg 3
    set_wr(1'b1, 5'd3, 64'hAAAA);
    for (int i = 0; i < 32; i++) begin
      R1addr = 5'(i);
      R2addr = 5'(31 - i);
      chk2("reset_read", 64'h0, 64'h0);
    end
    cyc();
    set_wr(1'b0, '0, '0);
    reset  = 1'b1;
    R1addr = 5'd3;
    R2addr = 5'd3;
    chk2("reset_no_write", 64'h0, 64'h0);

    // 2: basic write / read
    cyc();
    set_wr(1'b1, 5'd5, 64'h0123456789ABCDEF);
    R1addr = 5'd5;
    R2addr = 5'd6;
    chk("wr5_pre", 64'h0123456789ABCDEF, 64'h0, 64'h0, 64'h0);
    cyc();
    WB_WRegEn = 1'b0;
    R2addr    = 5'd5;
    chk2("rd5_both", 64'h0123456789ABCDEF, 64'h0123456789ABCDEF);
    R1addr = 5'd6;
    chk2("rd6_rd5", 64'h0, 64'h0123456789ABCDEF);

    // 3: bypass on port 1 only
    cyc();
    set_wr(1'b1, 5'd7, 64'h11);
    cyc();
    WB_WData = 64'h22;
    R1addr   = 5'd7;
    R2addr   = 5'd8;
    chk("byp_pre", 64'h22, 64'h0, 64'h11, 64'h0);
    cyc();
    WB_WRegEn = 1'b0;
    chk2("byp_post", 64'h22, 64'h0);

    // 4: sweep all registers, including reg 0
    for (int i = 0; i < 32; i++) begin
      set_wr(1'b1, 5'(i), 64'(256 + i));
      cyc();
    end
    WB_WRegEn = 1'b0;
    for (int i = 0; i < 32; i++) begin
      R1addr = 5'(i);
      R2addr = 5'(31 - i);
      chk2("sweep", 64'(256 + i), 64'(287 - i));
    end

    // 5: write enable low must neither write nor bypass
    set_wr(1'b0, 5'd9, 64'hDEAD);
    R1addr = 5'd9;
    R2addr = 5'd9;
    for (int k = 0; k < 3; k++) begin
      chk2("we_gate", 64'h109, 64'h109);
    end

    // back-to-back writes to reg 10
    cyc();
    set_wr(1'b1, 5'd10, 64'hA1);
    R1addr = 5'd10;
    R2addr = 5'd11;
    chk("b2b_a", 64'hA1, 64'h10B, 64'h10A, 64'h10B);
    cyc();
    WB_WData = 64'hB2;
    chk("b2b_b", 64'hB2, 64'h10B, 64'hA1, 64'h10B);
    cyc();
    WB_WData = 64'hC3;
    chk("b2b_c", 64'hC3, 64'h10B, 64'hB2, 64'h10B);
    cyc();
    WB_WRegEn = 1'b0;
    R2addr    = 5'd10;
    chk2("b2b_last", 64'hC3, 64'hC3);

    // 6: asynchronous reset between edges, with a write held across an edge
    cyc();
    #2;
    reset  = 1'b0;
    R1addr = 5'd2;
    R2addr = 5'd31;
    chk2("async_rst", 64'h0, 64'h0);
    set_wr(1'b1, 5'd4, 64'hBEEF);
    R1addr = 5'd4;
    R2addr = 5'd4;
    chk2("rst_bypass_off", 64'h0, 64'h0);
    cyc();
    set_wr(1'b1, 5'd2, 64'h5);
    reset = 1'b1;
    cyc();
    WB_WRegEn = 1'b0;
    for (int i = 0; i < 32; i++) begin
      R1addr = 5'(i);
      R2addr = 5'(i);
      chk2("post_rst", (i == 2) ? 64'h5 : 64'h0, (i == 2) ? 64'h5 : 64'h0);
    end

    // final report
    cyc();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
